// File: rtl/projetoniosqsys_mem_fill_check.sv
// Fill/verify engine for the on-chip RAM's second slave port: writes a seed+index
// pattern over a word range, or reads it back and counts/locates mismatches.
module projetoniosqsys_mem_fill_check #(
    parameter int DEPTH = 1840,
    parameter int AW    = 11,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [AW-1:0]     base,
    input  logic [AW:0]       len,
    input  logic [DW-1:0]     seed,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [AW:0]       err_cnt,
    output logic [AW-1:0]     first_err_addr,
    output logic [AW-1:0]     mem_address,
    output logic [DW/8-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DW-1:0]     mem_writedata,
    output logic              mem_clken,
    input  logic [DW-1:0]     mem_readdata
);

    localparam int BW = DW / 8;
    localparam logic [AW+1:0] DEPTH_V = (AW+2)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CHECK,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t                state;
    logic [AW-1:0]         base_r;
    logic [AW:0]           len_r;
    logic [DW-1:0]         seed_r;
    logic [AW:0]           idx;
    logic [DW-1:0]         pat;
    logic                  err_seen;
    logic                  vld_p0;
    logic [DW-1:0]         exp_p0;
    logic [AW-1:0]         addr_p0;
    logic [AW+1:0]         end_sum;
    logic                  range_bad;
    logic                  last_issue;
    logic                  mismatch;

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign mem_clken  = 1'b1;
    assign end_sum    = {2'b00, base} + {1'b0, len};
    assign range_bad  = end_sum > DEPTH_V;
    assign last_issue = abort || (idx == len_r);
    assign mismatch   = vld_p0 && (mem_readdata != exp_p0);

    // compare stage p0: expected word and address of the read presented this cycle
    always_ff @(posedge clk) begin
        exp_p0  <= pat;
        addr_p0 <= mem_address;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            base_r         <= '0;
            len_r          <= '0;
            seed_r         <= '0;
            idx            <= '0;
            pat            <= '0;
            vld_p0         <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_p0 <= mem_chipselect && !mem_write;

            if (mismatch) begin
                err_cnt <= sat_inc(err_cnt);
                if (!err_seen) begin
                    first_err_addr <= addr_p0;
                    err_seen       <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_r         <= base;
                        len_r          <= len;
                        seed_r         <= seed;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        err_seen       <= 1'b0;
                        cfg_err        <= 1'b0;
                        if (range_bad) begin
                            cfg_err <= 1'b1;
                            state   <= S_FIN;
                            done    <= 1'b1;
                        end else if (len == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state          <= mode ? S_CHECK : S_FILL;
                            busy           <= 1'b1;
                            mem_chipselect <= 1'b1;
                            mem_write      <= !mode;
                            mem_byteenable <= {BW{1'b1}};
                            mem_address    <= base;
                            mem_writedata  <= mode ? '0 : seed;
                            pat            <= seed;
                            idx            <= (AW+1)'(1);
                        end
                    end
                end

                S_FILL, S_CHECK: begin
                    if (last_issue) begin
                        mem_chipselect <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_byteenable <= '0;
                        mem_writedata  <= '0;
                        if (state == S_CHECK) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        mem_address <= base_r + idx[AW-1:0];
                        pat         <= pat + 1'b1;
                        if (state == S_FILL) begin
                            mem_writedata <= pat + 1'b1;
                        end
                        idx <= idx + 1'b1;
                    end
                end

                // final read word is compared on the edge leaving this state
                S_DRAIN: begin
                    state <= S_FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end

                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
